inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0, is the byte address of the first instruction-memory word written.
REQ-002 Parameter DEPTH, default 256, is the maximum number of words written per program (power of two, at least 2).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  one-cycle pulse; begins a new program at BASE_ADDR.
REQ-006 valid_i  input  1  field bundle on the inputs below is valid.
REQ-007 ready_o  output  1  encoder accepts the bundle this cycle.
REQ-008 class_i  input  3  0 R-type, 1 I-type, 2 load, 3 store, 4 branch; 5-7 illegal.
REQ-009 rd_i / rs1_i / rs2_i  input  5 each  register indices.
REQ-010 funct3_i  input  3; funct7_i  input  7.
REQ-011 imm_i  input  12  immediate; for branch it is offset bits [12:1].
REQ-012 valid_o  output  1  encoded word pending on the write port.
REQ-013 ready_i  input  1  instruction memory accepts the write this cycle.
REQ-014 addr_o  output  32  byte address of the pending word.
REQ-015 data_o  output  32  encoded instruction word.
REQ-016 count_o  output  $clog2(DEPTH)+1  number of words written since the last start.
REQ-017 full_o  output  1  DEPTH words written; no further input is accepted.
REQ-018 error_o  output  1  sticky; an illegal class was presented.

Function
REQ-019 The FSM SHALL have three states: IDLE (after reset), RUN, and FULL; start_i in any state SHALL go to RUN, clear count_o, full_o and error_o, set the write address to BASE_ADDR, and drop any pending word.
REQ-020 ready_o SHALL be 1 only in RUN, and only when valid_o is 0 or ready_i is 1 (a single output register with pass-through backpressure).
REQ-021 Acceptance (valid_i and ready_o) of a legal class SHALL load data_o and set valid_o on the next edge, giving latency 1.
REQ-022 Opcodes SHALL be: R 0110011, I 0010011, load 0000011, store 0100011, branch 1100011, each in bits [6:0].
REQ-023 R-type SHALL be funct7|rs2|rs1|funct3|rd|op; I-type and load SHALL be imm[11:0]|rs1|funct3|rd|op.
REQ-024 Store SHALL be imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
REQ-025 Branch SHALL place imm[11] at bit 31, imm[9:4] at [30:25], imm[3:0] at [11:8] and imm[10] at bit 7; rs2, rs1 and funct3 SHALL occupy their standard positions.
REQ-026 Acceptance of an illegal class SHALL consume the bundle, produce no word, and set error_o.
REQ-027 A write handshake (valid_o and ready_i) SHALL increment count_o, advance addr_o by 4, and clear valid_o unless a new word is accepted in the same cycle.
REQ-028 When the handshake that makes count_o equal DEPTH completes, the FSM SHALL enter FULL, assert full_o and deassert ready_o.
REQ-029 If start_i coincides with an input or write handshake, start_i SHALL win; that handshake SHALL not update count_o or addr_o.
REQ-030 data_o and addr_o SHALL hold stable while valid_o is 1 and ready_i is 0.

Reset
REQ-031 While rst_i is 0: state IDLE, valid_o 0, ready_o 0, data_o 0, addr_o BASE_ADDR, count_o 0, full_o 0, error_o 0; a reset mid-program SHALL discard any pending word.

Structure
REQ-032 The opcode constants and the class encodings SHALL live in the shared constants include file, next to the existing OPCODE_* definitions.
REQ-033 The pure combinational field-to-word packing SHALL be one sub-module, inst_pack; the FSM, the output register and the counters SHALL stay in inst_encoder.

Verification
REQ-034 Start, then R-type add (rd=3, rs1=1, rs2=2, f3=0, f7=0) with ready_i=1 -> data_o 32'h002081B3 at addr 0 one cycle after acceptance, count_o 1.
REQ-035 Store (rs1=2, rs2=5, f3=2, imm=12'h014) -> 32'h00512A23; branch (rs1=1, rs2=2, f3=0, imm=12'h004, i.e. offset 8) -> 32'h00208463.
REQ-036 Hold ready_i=0 for 5 cycles with a word pending -> ready_o=0, data_o and addr_o stable; release -> single write, addr then advances by 4.
REQ-037 DEPTH=4, stream 5 loads -> four writes at addr 0,4,8,12, full_o=1, fifth bundle never accepted; start_i -> count_o 0, ready_o 1.
REQ-038 Illegal class 6 -> error_o=1, no write, count_o unchanged; rst_i low mid-stream -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared constants for the instruction encoder: opcodes, field-bundle classes and FSM states.
package inst_encoder_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    // Classes 5..7 are undefined and flagged as illegal by the encoder.
    localparam logic [2:0] CLASS_R      = 3'd0;
    localparam logic [2:0] CLASS_I      = 3'd1;
    localparam logic [2:0] CLASS_LOAD   = 3'd2;
    localparam logic [2:0] CLASS_STORE  = 3'd3;
    localparam logic [2:0] CLASS_BRANCH = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } enc_state_e;

endpackage

// File: rtl/inst_pack.sv
// Purely combinational packing of a decoded field bundle into a 32-bit RV32I instruction word.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [2:0]  i_class,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [11:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_legal
);

    always_comb begin
        o_word  = '0;
        o_legal = 1'b1;
        case (i_class)
            CLASS_R:      o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OPCODE_OP};
            CLASS_I:      o_word = {i_imm, i_rs1, i_funct3, i_rd, OPCODE_OP_IMM};
            CLASS_LOAD:   o_word = {i_imm, i_rs1, i_funct3, i_rd, OPCODE_LOAD};
            CLASS_STORE:  o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPCODE_STORE};
            // i_imm holds branch offset bits [12:1], so every index is one below the ISA name.
            CLASS_BRANCH: o_word = {i_imm[11], i_imm[9:4], i_rs2, i_rs1, i_funct3,
                                    i_imm[3:0], i_imm[10], OPCODE_BRANCH};
            default:      o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Streams field bundles into encoded instruction words written to consecutive memory addresses,
// with a single output register, pass-through backpressure and a per-program word limit.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          DEPTH     = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [2:0]               class_i,
    input  logic [4:0]               rd_i,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    input  logic [2:0]               funct3_i,
    input  logic [6:0]               funct7_i,
    input  logic [11:0]              imm_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [31:0]              addr_o,
    output logic [31:0]              data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     error_o
);

    localparam int                 CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(DEPTH - 1);

    enc_state_e         r_state;
    enc_state_e         w_state_nxt;
    logic               r_valid;
    logic [31:0]        r_data;
    logic [31:0]        r_addr;
    logic [CNT_W-1:0]   r_count;
    logic               r_error;

    logic [31:0]        w_word;
    logic               w_legal;
    logic               w_acc;
    logic               w_wr;
    logic               w_last;

    inst_pack u_pack (
        .i_class  (class_i),
        .i_rd     (rd_i),
        .i_rs1    (rs1_i),
        .i_rs2    (rs2_i),
        .i_funct3 (funct3_i),
        .i_funct7 (funct7_i),
        .i_imm    (imm_i),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    // Refuse a new bundle alongside the final write so no word is ever built past DEPTH.
    assign w_last  = (r_count == LAST);
    assign ready_o = (r_state == ST_RUN) && (!r_valid || (ready_i && !w_last));
    assign w_acc   = valid_i && ready_o;
    assign w_wr    = r_valid && ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start_i)
            w_state_nxt = ST_RUN;
        else if ((r_state == ST_RUN) && w_wr && w_last)
            w_state_nxt = ST_FULL;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
            r_error <= 1'b0;
        end else if (start_i) begin
            r_valid <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_wr) begin
                r_count <= r_count + 1'b1;
                r_addr  <= r_addr + 32'd4;
            end
            if (w_acc && w_legal) begin
                r_valid <= 1'b1;
                r_data  <= w_word;
            end else if (w_wr) begin
                r_valid <= 1'b0;
            end
            if (w_acc && !w_legal)
                r_error <= 1'b1;
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign addr_o  = r_addr;
    assign count_o = r_count;
    assign full_o  = (r_state == ST_FULL);
    assign error_o = r_error;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors, corner sequences and a randomized model check.
module tb_inst_encoder;

    localparam logic [31:0] BASE  = 32'h0;
    localparam int          DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  class_i = '0;
    logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [6:0]  funct7_i = '0;
    logic [11:0] imm_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] addr_o, data_o;
    logic [$clog2(DEPTH):0] count_o;
    logic        full_o, error_o;

    int checks = 0;
    int errors = 0;

    inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .valid_i(valid_i), .ready_o(ready_o),
        .class_i(class_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .imm_i(imm_i), .valid_o(valid_o), .ready_i(ready_i),
        .addr_o(addr_o), .data_o(data_o), .count_o(count_o), .full_o(full_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic set_bundle(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [11:0] imm);
        class_i = c; rd_i = rd; rs1_i = r1; rs2_i = r2; funct3_i = f3; funct7_i = f7; imm_i = imm;
    endtask

    // Builds the word from ISA field positions; branch immediate is rebuilt as a byte offset first.
    function automatic logic [31:0] ref_encode(input logic [2:0] cls, input logic [4:0] rd,
            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
            input logic [6:0] f7, input logic [11:0] imm);
        logic [31:0] regs;
        logic [31:0] off;
        regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
        off  = 32'(imm) * 2;
        case (cls)
            3'd0: return (32'(f7) << 25) | regs | (32'(rd) << 7) | 32'h33;
            3'd1: return (32'(imm) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h13;
            3'd2: return (32'(imm) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h03;
            3'd3: return ((32'(imm) >> 5) << 25) | regs | ((32'(imm) & 32'd31) << 7) | 32'h23;
            3'd4: return (((off >> 12) & 32'd1) << 31) | (((off >> 5) & 32'd63) << 25) | regs
                        | (((off >> 1) & 32'd15) << 8) | (((off >> 11) & 32'd1) << 7) | 32'h63;
            default: return 32'h0;
        endcase
    endfunction

    int          m_mode;
    int          m_count;
    logic [31:0] m_addr;
    bit          m_pend;
    logic [31:0] m_word;
    bit          m_err;

    initial begin
        int writes, accepts;
        bit exp_ready, acc, wr;

        vecs[0] = '{3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 12'h000, 32'h002081B3};
        vecs[1] = '{3'd3, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 12'h014, 32'h00512A23};
        vecs[2] = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 12'h004, 32'h00208463};
        vecs[3] = '{3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 12'h005, 32'h00500093};
        vecs[4] = '{3'd2, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 12'h008, 32'h00812283};
        vecs[5] = '{3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'hFFE, 32'hFE000EE3};
        vecs[6] = '{3'd0, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 12'h000, 32'h407302B3};

        #3;
        valid_i = 1'b1;
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd0);
        chk("rst_data_o",  data_o, 32'd0);
        chk("rst_addr_o",  addr_o, BASE);
        chk("rst_count_o", 32'(count_o), 32'd0);
        chk("rst_full_o",  32'(full_o), 32'd0);
        chk("rst_error_o", 32'(error_o), 32'd0);
        valid_i = 1'b0;
        #20 rst_i = 1'b1;
        tick();

        chk("idle_ready_o", 32'(ready_o), 32'd0);

        for (int i = 0; i < 7; i++) begin
            pulse_start();
            set_bundle(vecs[i].cls, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7, vecs[i].imm);
            valid_i = 1'b1;
            ready_i = 1'b1;
            #1;
            chk("vec_ready_o", 32'(ready_o), 32'd1);
            tick();
            valid_i = 1'b0;
            chk("vec_valid_o", 32'(valid_o), 32'd1);
            chk("vec_data_o", data_o, vecs[i].exp);
            chk("vec_addr_o", addr_o, BASE);
            tick();
            chk("vec_count_o", 32'(count_o), 32'd1);
            chk("vec_addr_next", addr_o, BASE + 32'd4);
            chk("vec_valid_clr", 32'(valid_o), 32'd0);
        end

        // Backpressure: word stays put while the memory stalls, then exactly one write.
        pulse_start();
        set_bundle(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 12'h000);
        valid_i = 1'b1;
        ready_i = 1'b0;
        tick();
        set_bundle(3'd3, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 12'h014);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_o", 32'(ready_o), 32'd0);
            chk("bp_valid_o", 32'(valid_o), 32'd1);
            chk("bp_data_o", data_o, 32'h002081B3);
            chk("bp_addr_o", addr_o, BASE);
            tick();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        chk("bp_count_o", 32'(count_o), 32'd1);
        chk("bp_addr_adv", addr_o, BASE + 32'd4);
        chk("bp_valid_clr", 32'(valid_o), 32'd0);
        tick();
        chk("bp_single_write", 32'(count_o), 32'd1);

        // Fill to DEPTH with a continuous stream of five loads.
        pulse_start();
        set_bundle(3'd2, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 12'h008);
        valid_i = 1'b1;
        ready_i = 1'b1;
        writes = 0;
        accepts = 0;
        for (int i = 0; i < 14; i++) begin
            if (valid_o && ready_i) begin
                chk("full_wr_addr", addr_o, BASE + 32'(writes * 4));
                writes++;
            end
            if (ready_o && valid_i && accepts < 5) accepts++;
            if (accepts == 5) valid_i = 1'b0;
            tick();
        end
        chk("full_writes", 32'(writes), 32'd4);
        chk("full_accepts", 32'(accepts), 32'd4);
        chk("full_full_o", 32'(full_o), 32'd1);
        chk("full_count_o", 32'(count_o), 32'd4);
        valid_i = 1'b1;
        #1;
        chk("full_ready_o", 32'(ready_o), 32'd0);
        valid_i = 1'b0;
        pulse_start();
        chk("restart_count_o", 32'(count_o), 32'd0);
        chk("restart_full_o", 32'(full_o), 32'd0);
        chk("restart_ready_o", 32'(ready_o), 32'd1);

        // start_i collides with both an input and a write handshake.
        set_bundle(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 12'h000);
        valid_i = 1'b1;
        ready_i = 1'b0;
        tick();
        ready_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        valid_i = 1'b0;
        chk("startwin_count_o", 32'(count_o), 32'd0);
        chk("startwin_addr_o", addr_o, BASE);
        chk("startwin_valid_o", 32'(valid_o), 32'd0);

        // Illegal class.
        set_bundle(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 12'h000);
        valid_i = 1'b1;
        #1;
        chk("ill_ready_o", 32'(ready_o), 32'd1);
        tick();
        valid_i = 1'b0;
        chk("ill_error_o", 32'(error_o), 32'd1);
        chk("ill_valid_o", 32'(valid_o), 32'd0);
        tick();
        chk("ill_count_o", 32'(count_o), 32'd0);
        chk("ill_error_sticky", 32'(error_o), 32'd1);
        pulse_start();
        chk("ill_error_clr", 32'(error_o), 32'd0);

        // Asynchronous reset mid-stream.
        set_bundle(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 12'h005);
        valid_i = 1'b1;
        ready_i = 1'b1;
        tick();
        tick();
        #2 rst_i = 1'b0;
        #1;
        chk("arst_valid_o", 32'(valid_o), 32'd0);
        chk("arst_ready_o", 32'(ready_o), 32'd0);
        chk("arst_data_o", data_o, 32'd0);
        chk("arst_addr_o", addr_o, BASE);
        chk("arst_count_o", 32'(count_o), 32'd0);
        chk("arst_full_o", 32'(full_o), 32'd0);
        chk("arst_error_o", 32'(error_o), 32'd0);
        valid_i = 1'b0;
        ready_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();

        // Randomized run against the reference model.
        m_mode = 0; m_count = 0; m_addr = BASE; m_pend = 0; m_word = '0; m_err = 0;
        for (int n = 0; n < 3000; n++) begin
            start_i = ($urandom_range(0, (m_mode == 2) ? 3 : 15) == 0);
            valid_i = ($urandom_range(0, 1) == 1);
            ready_i = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) < 8) class_i = 3'($urandom_range(0, 4));
            else                          class_i = 3'($urandom_range(5, 7));
            rd_i = 5'($urandom); rs1_i = 5'($urandom); rs2_i = 5'($urandom);
            funct3_i = 3'($urandom); funct7_i = 7'($urandom); imm_i = 12'($urandom);
            #1;
            exp_ready = (m_mode == 1) && (!m_pend || ready_i) && (m_count + int'(m_pend) < DEPTH);
            chk("rnd_ready_o", 32'(ready_o), 32'(exp_ready));
            acc = valid_i && exp_ready;
            wr  = m_pend && ready_i;
            if (start_i) begin
                m_mode = 1; m_count = 0; m_addr = BASE; m_pend = 0; m_err = 0;
            end else begin
                if (wr) begin
                    m_count++;
                    m_addr = m_addr + 32'd4;
                    m_pend = 0;
                    if (m_count == DEPTH) m_mode = 2;
                end
                if (acc) begin
                    if (class_i <= 3'd4) begin
                        m_pend = 1;
                        m_word = ref_encode(class_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i);
                    end else begin
                        m_err = 1;
                    end
                end
            end
            tick();
            start_i = 1'b0;
            chk("rnd_valid_o", 32'(valid_o), 32'(m_pend));
            if (m_pend) chk("rnd_data_o", data_o, m_word);
            chk("rnd_addr_o", addr_o, m_addr);
            chk("rnd_count_o", 32'(count_o), 32'(m_count));
            chk("rnd_full_o", 32'(full_o), 32'(m_mode == 2));
            chk("rnd_error_o", 32'(error_o), 32'(m_err));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
